// File: rtl/bdd_table_loader.sv
// bdd_table_loader
// Framed byte-stream programmer for the two BDD accelerator tables.
// A frame is: HDR {sel, 3'bx, cnt[3:0]}, ADDR byte, then cnt+1 words sent
// MSB first (RAM1 words use B1 bytes, RAM2 words use B2 bytes).
// Every assembled word is written with a single-cycle we1/we2 strobe.
// The write port shares one in_addr, which advances and wraps inside the frame.
// The loader takes no byte during a strobe cycle, so each word costs B+1 cycles.

module bdd_table_loader #(
    parameter int RAM1_DATA_WIDTH = 34,
    parameter int RAM2_DATA_WIDTH = 18,
    parameter int ADDR_WIDTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 s_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    output logic                       we1,
    output logic                       we2,
    output logic [ADDR_WIDTH-1:0]      in_addr,
    output logic [RAM1_DATA_WIDTH-1:0] ram1_data_in,
    output logic [RAM2_DATA_WIDTH-1:0] ram2_data_in,
    output logic                       busy,
    output logic                       load_done
);

    // Bytes per word for each table, and the assembly register width.
    // The assembly register only needs to be as wide as the widest word.
    // Bits shifted out above that width are exactly the ignored excess bits.
    localparam int B1    = (RAM1_DATA_WIDTH + 7) / 8;
    localparam int B2    = (RAM2_DATA_WIDTH + 7) / 8;
    localparam int BMAX  = (B1 > B2) ? B1 : B2;
    localparam int ASM_W = (RAM1_DATA_WIDTH > RAM2_DATA_WIDTH) ? RAM1_DATA_WIDTH
                                                               : RAM2_DATA_WIDTH;
    localparam int BC_W  = (BMAX > 1) ? $clog2(BMAX) : 1;

    localparam logic [BC_W-1:0] B1_LAST = BC_W'(B1 - 1);
    localparam logic [BC_W-1:0] B2_LAST = BC_W'(B2 - 1);

    typedef enum logic [1:0] {
        S_HDR  = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_WR   = 2'd3
    } state_t;

    state_t                     state_q, state_d;
    logic                       sel_q, sel_d;        // 0 = RAM1, 1 = RAM2
    logic [3:0]                 cnt_q, cnt_d;        // words remaining after current
    logic [ADDR_WIDTH-1:0]      addr_q, addr_d;      // address of the word in assembly
    logic [BC_W-1:0]            bcnt_q, bcnt_d;      // bytes of current word accepted
    logic [ASM_W-1:0]           asm_q, asm_d;        // word assembly shift register

    logic                       s_ready_q, s_ready_d;
    logic                       we1_q, we1_d;
    logic                       we2_q, we2_d;
    logic [ADDR_WIDTH-1:0]      in_addr_q, in_addr_d;
    logic [RAM1_DATA_WIDTH-1:0] ram1_q, ram1_d;
    logic [RAM2_DATA_WIDTH-1:0] ram2_q, ram2_d;
    logic                       busy_q, busy_d;
    logic                       load_done_q, load_done_d;

    logic                       accept;
    logic [BC_W-1:0]            word_last;
    logic [ASM_W-1:0]           asm_shift;

    // Next-state, datapath and registered-output logic for the frame parser.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        bcnt_d      = bcnt_q;
        asm_d       = asm_q;
        we1_d       = 1'b0;
        we2_d       = 1'b0;
        load_done_d = 1'b0;
        in_addr_d   = in_addr_q;
        ram1_d      = ram1_q;
        ram2_d      = ram2_q;

        // A byte is taken only when the registered ready is high.
        // The host sees exactly this same ready value.
        accept    = s_valid && s_ready_q;
        word_last = sel_q ? B2_LAST : B1_LAST;
        asm_shift = (asm_q << 8) | ASM_W'(s_data);

        case (state_q)
            S_HDR: begin
                if (accept) begin
                    sel_d   = s_data[7];
                    cnt_d   = s_data[3:0];
                    state_d = S_ADDR;
                end
            end

            S_ADDR: begin
                if (accept) begin
                    addr_d  = s_data[ADDR_WIDTH-1:0];
                    bcnt_d  = '0;
                    state_d = S_DATA;
                end
            end

            S_DATA: begin
                if (accept) begin
                    asm_d = asm_shift;
                    if (bcnt_q == word_last) begin
                        // The last byte of the word has arrived.
                        // Drive the strobe and data straight into the output registers.
                        bcnt_d      = '0;
                        state_d     = S_WR;
                        in_addr_d   = addr_q;
                        load_done_d = (cnt_q == 4'd0);
                        if (sel_q) begin
                            we2_d  = 1'b1;
                            ram2_d = asm_shift[RAM2_DATA_WIDTH-1:0];
                        end else begin
                            we1_d  = 1'b1;
                            ram1_d = asm_shift[RAM1_DATA_WIDTH-1:0];
                        end
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
            end

            S_WR: begin
                // Strobe cycle: advance the address, which wraps naturally.
                // Then either fetch the next word or end the frame.
                addr_d = addr_q + 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = S_HDR;
                end else begin
                    cnt_d   = cnt_q - 1'b1;
                    state_d = S_DATA;
                end
            end

            default: begin
                state_d = S_HDR;
            end
        endcase

        s_ready_d = (state_d != S_WR);
        busy_d    = (state_d != S_HDR);
    end

    // State and output registers; active-low synchronous reset discards any partial frame.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_HDR;
            sel_q       <= 1'b0;
            cnt_q       <= '0;
            addr_q      <= '0;
            bcnt_q      <= '0;
            asm_q       <= '0;
            s_ready_q   <= 1'b0;
            we1_q       <= 1'b0;
            we2_q       <= 1'b0;
            in_addr_q   <= '0;
            ram1_q      <= '0;
            ram2_q      <= '0;
            busy_q      <= 1'b0;
            load_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            bcnt_q      <= bcnt_d;
            asm_q       <= asm_d;
            s_ready_q   <= s_ready_d;
            we1_q       <= we1_d;
            we2_q       <= we2_d;
            in_addr_q   <= in_addr_d;
            ram1_q      <= ram1_d;
            ram2_q      <= ram2_d;
            busy_q      <= busy_d;
            load_done_q <= load_done_d;
        end
    end

    assign s_ready      = s_ready_q;
    assign we1          = we1_q;
    assign we2          = we2_q;
    assign in_addr      = in_addr_q;
    assign ram1_data_in = ram1_q;
    assign ram2_data_in = ram2_q;
    assign busy         = busy_q;
    assign load_done    = load_done_q;

endmodule
